// File: rtl/tt_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tt_sweep_ctrl
// Function : Drives a combinational netlist through every input combination,
//            streams the captured outputs and accumulates mismatch statistics.
// Revision : 1.0  initial release
// ============================================================================
module tt_sweep_ctrl #(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 6,
  parameter int SETTLE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [(2**N_IN)*N_OUT-1:0] exp_tt,
  output logic [N_IN-1:0]            x_drv,
  input  logic [N_OUT-1:0]           f_in,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [N_IN-1:0]            res_idx,
  output logic [N_OUT-1:0]           res_data,
  output logic                       res_err,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [N_IN:0]              err_cnt,
  output logic [N_IN-1:0]            first_err
);

  localparam int                 c_tt_w        = (2**N_IN)*N_OUT;
  localparam int                 c_cnt_w       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0]    c_idx_last    = '1;
  localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [N_IN-1:0]     idx_q, idx_d;
  logic [c_cnt_w-1:0]  settle_q, settle_d;
  logic [c_tt_w-1:0]   exp_q, exp_d;
  logic                res_valid_q, res_valid_d;
  logic [N_IN-1:0]     res_idx_q, res_idx_d;
  logic [N_OUT-1:0]    res_data_q, res_data_d;
  logic                res_err_q, res_err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [N_IN:0]       err_cnt_q, err_cnt_d;
  logic [N_IN-1:0]     first_err_q, first_err_d;

  logic [N_OUT-1:0]    w_exp;
  logic                w_mismatch;

  assign w_exp      = exp_q[idx_q*N_OUT +: N_OUT];
  assign w_mismatch = (f_in != w_exp);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    settle_d    = settle_q;
    exp_d       = exp_q;
    res_valid_d = res_valid_q;
    res_idx_d   = res_idx_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_APPLY;
          idx_d       = '0;
          settle_d    = '0;
          exp_d       = exp_tt;
          err_cnt_d   = '0;
          first_err_d = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
        end
      end
      S_APPLY: begin
        if (settle_q == c_settle_last) begin
          state_d     = S_SAMPLE;
          settle_d    = '0;
          res_valid_d = 1'b1;
          res_data_d  = f_in;
          res_idx_d   = idx_q;
          res_err_d   = w_mismatch;
          if (w_mismatch) begin
            err_cnt_d = err_cnt_q + (N_IN+1)'(1);
            if (err_cnt_q == '0) first_err_d = idx_q;
          end
        end else begin
          settle_d = settle_q + c_cnt_w'(1);
        end
      end
      S_SAMPLE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          // Last index is matched explicitly so idx never wraps back to 0.
          if (idx_q == c_idx_last) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_q == '0);
          end else begin
            state_d = S_APPLY;
            idx_d   = idx_q + N_IN'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides start and the handshake; statistics and x_drv are kept.
    if (abort) begin
      state_d     = S_IDLE;
      settle_d    = '0;
      res_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      settle_q    <= '0;
      exp_q       <= '0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      settle_q    <= settle_d;
      exp_q       <= exp_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

  assign x_drv     = idx_q;
  assign res_valid = res_valid_q;
  assign res_idx   = res_idx_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_cnt_q;
  assign first_err = first_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_sweep_ctrl
// Function : Self-checking bench for tt_sweep_ctrl (scenario table + scoreboard).
// Revision : 1.0  initial release
// ============================================================================
module tb_tt_sweep_ctrl;

  localparam logic [23:0] EXP_TT = 24'h1264EB;

  typedef struct packed {
    logic [1:0] idx;
    logic [5:0] data;
    logic       err;
  } res_t;

  typedef struct {
    logic [23:0] ftab;
    int          poke;
    logic [2:0]  ecnt;
    logic [1:0]  efirst;
    logic        epass;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] gtab;

  // Unit under test with SETTLE=1 and an instant netlist model
  logic        start1, abort1, ready1;
  logic [23:0] exp1, ftab1;
  logic [1:0]  x1, idx1, first1;
  logic [5:0]  f1, data1;
  logic        valid1, err1, busy1, done1, pass1;
  logic [2:0]  ecnt1;

  // Second unit with SETTLE=3 and a slow netlist model
  logic        start3, abort3, ready3;
  logic [1:0]  x3, idx3, first3, last3;
  logic [5:0]  f3, data3;
  logic        valid3, err3, busy3, done3, pass3;
  logic [2:0]  ecnt3;
  int          age3;

  res_t        q1[$];
  res_t        q3[$];
  res_t        r1, r3;
  vec_t        vt[4];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc;

  always #5 clk = ~clk;

  tt_sweep_ctrl #(.N_IN(2), .N_OUT(6), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .exp_tt(exp1),
    .x_drv(x1), .f_in(f1), .res_valid(valid1), .res_ready(ready1),
    .res_idx(idx1), .res_data(data1), .res_err(err1), .busy(busy1),
    .done(done1), .pass(pass1), .err_cnt(ecnt1), .first_err(first1)
  );

  tt_sweep_ctrl #(.N_IN(2), .N_OUT(6), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .exp_tt(gtab),
    .x_drv(x3), .f_in(f3), .res_valid(valid3), .res_ready(ready3),
    .res_idx(idx3), .res_data(data3), .res_err(err3), .busy(busy3),
    .done(done3), .pass(pass3), .err_cnt(ecnt3), .first_err(first3)
  );

  assign f1 = ftab1[int'(x1)*6 +: 6];

  // Slow netlist: output is inverted garbage until 2 cycles after x changes
  always @(negedge clk) begin
    if (x3 != last3) begin
      last3 <= x3;
      age3  <= 0;
    end else if (age3 < 3) begin
      age3 <= age3 + 1;
    end
  end
  assign f3 = (x3 == last3 && age3 >= 2) ? gtab[int'(x3)*6 +: 6] : ~gtab[int'(x3)*6 +: 6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (valid1 && ready1) begin
      if (q1.size() == 0) begin
        n_chk++;
        $display("FAIL sb1_extra: got idx %0d, expected no result", idx1);
      end else begin
        r1 = q1.pop_front();
        chk("sb1_idx", 32'(idx1), 32'(r1.idx));
        chk("sb1_data", 32'(data1), 32'(r1.data));
        chk("sb1_err", 32'(err1), 32'(r1.err));
      end
    end
    if (valid3 && ready3) begin
      if (q3.size() == 0) begin
        n_chk++;
        $display("FAIL sb3_extra: got idx %0d, expected no result", idx3);
      end else begin
        r3 = q3.pop_front();
        chk("sb3_idx", 32'(idx3), 32'(r3.idx));
        chk("sb3_data", 32'(data3), 32'(r3.data));
        chk("sb3_err", 32'(err3), 32'(r3.err));
      end
    end
  end

  task automatic push(input bit to3, input logic [23:0] ft, input int lo, input int hi);
    res_t r;
    for (int i = lo; i <= hi; i++) begin
      r.idx  = 2'(i);
      r.data = ft[i*6 +: 6];
      r.err  = (ft[i*6 +: 6] != gtab[i*6 +: 6]);
      if (to3) q3.push_back(r);
      else     q1.push_back(r);
    end
  endtask

  task automatic chk_reset1(input string tag);
    chk({tag, "_x_drv"}, 32'(x1), 0);
    chk({tag, "_valid"}, 32'(valid1), 0);
    chk({tag, "_idx"}, 32'(idx1), 0);
    chk({tag, "_data"}, 32'(data1), 0);
    chk({tag, "_err"}, 32'(err1), 0);
    chk({tag, "_busy"}, 32'(busy1), 0);
    chk({tag, "_done"}, 32'(done1), 0);
    chk({tag, "_pass"}, 32'(pass1), 0);
    chk({tag, "_err_cnt"}, 32'(ecnt1), 0);
    chk({tag, "_first_err"}, 32'(first1), 0);
  endtask

  // Pulses start, optionally re-pulses it at cycle 'poke', scrambles exp_tt
  // after acceptance, and returns the cycle count at which done was seen.
  task automatic run_sweep1(input int poke, output int c);
    start1 = 1'b1;
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
      start1 = (c == poke);
      if (c == 2) exp1 = ~gtab;
    end while (!done1 && c < 200);
    start1 = 1'b0;
    exp1   = gtab;
  endtask

  initial begin
    gtab   = EXP_TT;
    exp1   = EXP_TT;
    ftab1  = EXP_TT;
    last3  = 2'd0;
    age3   = 3;
    rst_n  = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1;
    start3 = 1'b0; abort3 = 1'b0; ready3 = 1'b1;

    vt[0] = '{ftab: {6'h04, 6'h26, 6'h13, 6'h2B}, poke: 0, ecnt: 3'd0, efirst: 2'd0, epass: 1'b1};
    vt[1] = '{ftab: {6'h05, 6'h27, 6'h13, 6'h2B}, poke: 0, ecnt: 3'd2, efirst: 2'd2, epass: 1'b0};
    vt[2] = '{ftab: 24'h000000,                   poke: 4, ecnt: 3'd4, efirst: 2'd0, epass: 1'b0};
    vt[3] = '{ftab: {6'h3F, 6'h26, 6'h13, 6'h2B}, poke: 0, ecnt: 3'd1, efirst: 2'd3, epass: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk_reset1("rst");
    chk("rst3_x_drv", 32'(x3), 0);
    chk("rst3_busy", 32'(busy3), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      ftab1 = vt[i].ftab;
      push(1'b0, vt[i].ftab, 0, 3);
      run_sweep1(vt[i].poke, cyc);
      chk($sformatf("v%0d_done_cycle", i), 32'(cyc), 9);
      chk($sformatf("v%0d_pass", i), 32'(pass1), 32'(vt[i].epass));
      chk($sformatf("v%0d_err_cnt", i), 32'(ecnt1), 32'(vt[i].ecnt));
      chk($sformatf("v%0d_first_err", i), 32'(first1), 32'(vt[i].efirst));
      chk($sformatf("v%0d_busy", i), 32'(busy1), 0);
      chk($sformatf("v%0d_x_drv", i), 32'(x1), 3);
      chk($sformatf("v%0d_sb_drained", i), 32'(q1.size()), 0);
    end

    // Back-pressure: hold res_ready low for 3 cycles while idx1 is presented
    ftab1 = EXP_TT;
    push(1'b0, EXP_TT, 0, 3);
    start1 = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      start1 = 1'b0;
      cyc++;
      if (x1 == 2'd1) ready1 = 1'b0;
    end while (!(valid1 && idx1 == 2'd1) && cyc < 50);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d_valid", k), 32'(valid1), 1);
      chk($sformatf("stall%0d_idx", k), 32'(idx1), 1);
      chk($sformatf("stall%0d_data", k), 32'(data1), 32'h13);
      chk($sformatf("stall%0d_x_drv", k), 32'(x1), 1);
      if (k < 2) begin
        @(posedge clk); #1;
      end
    end
    ready1 = 1'b1;
    cyc = 0;
    while (!done1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("stall_done", 32'(done1), 1);
    chk("stall_pass", 32'(pass1), 1);
    chk("stall_sb_drained", 32'(q1.size()), 0);

    // Abort while idx2 is being presented
    ftab1 = vt[1].ftab;
    push(1'b0, vt[1].ftab, 0, 1);
    start1 = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      start1 = 1'b0;
      cyc++;
      if (x1 == 2'd2) ready1 = 1'b0;
    end while (!(valid1 && idx1 == 2'd2) && cyc < 50);
    chk("abort_pre_err_cnt", 32'(ecnt1), 1);
    abort1 = 1'b1;
    @(posedge clk); #1;
    abort1 = 1'b0;
    chk("abort_valid", 32'(valid1), 0);
    chk("abort_busy", 32'(busy1), 0);
    chk("abort_done", 32'(done1), 0);
    chk("abort_pass", 32'(pass1), 0);
    chk("abort_err_cnt_hold", 32'(ecnt1), 1);
    chk("abort_first_err_hold", 32'(first1), 2);
    chk("abort_x_drv_hold", 32'(x1), 2);
    chk("abort_sb_drained", 32'(q1.size()), 0);
    ready1 = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle_valid", 32'(valid1), 0);
    push(1'b0, vt[1].ftab, 0, 3);
    run_sweep1(0, cyc);
    chk("restart_done_cycle", 32'(cyc), 9);
    chk("restart_err_cnt", 32'(ecnt1), 2);
    chk("restart_first_err", 32'(first1), 2);
    chk("restart_sb_drained", 32'(q1.size()), 0);

    // Reset mid-APPLY, with a start pulse while busy beforehand
    ftab1 = EXP_TT;
    push(1'b0, EXP_TT, 0, 0);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(posedge clk); #1;
    chk("busy_before_poke", 32'(busy1), 1);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("poke_ignored_x_drv", 32'(x1), 1);
    chk("poke_apply_valid", 32'(valid1), 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset1("midrst");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_result", 32'(valid1), 0);
    chk("midrst_sb_drained", 32'(q1.size()), 0);

    // SETTLE=3 against a netlist that only settles after 2 cycles
    push(1'b1, EXP_TT, 0, 3);
    start3 = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      start3 = 1'b0;
      cyc++;
    end while (!done3 && cyc < 200);
    chk("s3_done_cycle", 32'(cyc), 17);
    chk("s3_pass", 32'(pass3), 1);
    chk("s3_err_cnt", 32'(ecnt3), 0);
    chk("s3_sb_drained", 32'(q3.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
